// File: rtl/mux_pkg.sv
// Shared constants and parameter sanity helper for the m:1 mux and its
// serial-to-parallel partner, demux_deser.
package mux_pkg;

    localparam int MUX_N = 3;
    localparam int MUX_M = 8;

    // True when the slot count m is exactly 2**n, so an n-bit select
    // addresses every slot with no unused codes.
    function automatic bit slots_match(input int n, input int m);
        return (n > 0) && (n < 31) && (m == (1 << n));
    endfunction

endpackage

// File: rtl/demux_deser_slot_counter.sv
// Mod-m up counter producing a slot select. Also intended to drive the mux
// select of a future serializer.
module slot_counter
    import mux_pkg::*;
#(
    parameter int n = MUX_N,
    parameter int m = MUX_M
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [n-1:0] sel,
    output logic         last
);

    localparam logic [n-1:0] LAST_SLOT = n'(m - 1);

    logic [n-1:0] sel_reg;

    // Count accepted items, wrapping from the last slot back to zero; clr wins over inc.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sel_reg <= '0;
        end else if (inc) begin
            sel_reg <= (sel_reg == LAST_SLOT) ? '0 : sel_reg + 1'b1;
        end
    end

    assign sel  = sel_reg;
    assign last = (sel_reg == LAST_SLOT);

endmodule

// File: rtl/demux_deser.sv
// Serial-to-parallel demux: steers one bit per cycle into slot sel and
// presents each completed m-bit word on a valid/ready output. Bit k of the
// word is the k-th bit received, so an m:1 mux with select k recovers it.
module demux_deser
    import mux_pkg::*;
#(
    parameter int n = MUX_N,
    parameter int m = MUX_M
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_bit,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [n-1:0] sel,
    output logic [m-1:0] out,
    output logic         out_valid,
    input  logic         out_ready
);

    if (!slots_match(n, m)) begin : g_bad_params
        $fatal(1, "demux_deser: m (%0d) must equal 2**n (n = %0d)", m, n);
    end

    logic         last;
    logic         acc;
    logic         load;
    logic         consume;
    logic [m-2:0] assembly;
    logic [m-1:0] out_reg;
    logic         out_valid_reg;

    // Only the final bit of a word can collide with an unconsumed word, so
    // the stall is confined to the last slot. No path from in_valid.
    assign in_ready = !(last && out_valid_reg && !out_ready);
    assign acc      = in_valid && in_ready;
    assign load     = acc && last && !clr;
    assign consume  = out_valid_reg && out_ready;

    slot_counter #(
        .n(n),
        .m(m)
    ) u_slot_counter (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (acc),
        .sel (sel),
        .last(last)
    );

    // The last slot is never stored: its bit goes straight into the output
    // word, so only m-1 assembly bits exist.
    for (genvar gi = 0; gi < m - 1; gi++) begin : g_slot
        localparam logic [n-1:0] SLOT = n'(gi);
        logic bit_reg;

        // Capture the incoming bit when it targets this slot; clear on abort or word completion.
        always_ff @(posedge clk) begin
            if (rst || clr || load) begin
                bit_reg <= 1'b0;
            end else if (acc && (sel == SLOT)) begin
                bit_reg <= in_bit;
            end
        end

        assign assembly[gi] = bit_reg;
    end

    // Output word register: a new load takes precedence over consumption so
    // back-to-back words keep out_valid high; out is held after consumption.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else if (load) begin
            out_reg       <= {in_bit, assembly};
            out_valid_reg <= 1'b1;
        end else if (consume) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_demux_deser.sv
// Self-checking bench for demux_deser: a cycle-level reference model checks
// sel/in_ready/out/out_valid every cycle, and completed words go through a
// scoreboard queue that is popped on each output handshake.
module tb_demux_deser;
    import mux_pkg::*;

    localparam int N = MUX_N;
    localparam int M = MUX_M;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic         in_bit;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] sel;
    logic [M-1:0] out;
    logic         out_valid;
    logic         out_ready;

    int vectors     = 0;
    int miscompares = 0;
    int cycle_cnt   = 0;

    logic [M-1:0] exp_q[$];

    // reference model state
    bit           model_known = 1'b0;
    int           model_cnt   = 0;
    logic [M-1:0] model_word  = '0;
    logic [M-1:0] model_out   = '0;
    logic         model_valid = 1'b0;

    always #5 clk = ~clk;

    demux_deser #(
        .n(N),
        .m(M)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_bit   (in_bit),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .out      (out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    function automatic logic mux8(input logic [M-1:0] w, input int k);
        return w[k];
    endfunction

    // One clock cycle: check DUT against the model at the falling edge,
    // advance the model with the inputs the rising edge will see.
    task automatic tick(output bit accepted);
        bit           exp_ready;
        bit           load;
        logic [M-1:0] exp_w;
        @(negedge clk);
        exp_ready = !(model_cnt == M - 1 && model_valid && !out_ready);
        accepted  = 1'b0;
        if (model_known) begin
            vectors++;
            if (sel !== N'(model_cnt) || out_valid !== model_valid ||
                in_ready !== exp_ready || out !== model_out) begin
                miscompares++;
                $display("FAIL cycle_state t=%0t sel=%0d req %0d out_valid=%b req %b in_ready=%b req %b out=%h req %h",
                         $time, sel, model_cnt, out_valid, model_valid, in_ready, exp_ready, out, model_out);
            end
            if (!rst && model_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_empty out=%h req none", out);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (out !== exp_w) begin
                        miscompares++;
                        $display("FAIL sb_word out=%h req %h", out, exp_w);
                    end else begin
                        $display("word consumed out=%h t=%0t", out, $time);
                    end
                end
            end
        end
        if (rst) begin
            model_known = 1'b1;
            model_cnt   = 0;
            model_word  = '0;
            model_out   = '0;
            model_valid = 1'b0;
            exp_q.delete();
        end else begin
            load = 1'b0;
            if (clr) begin
                model_cnt  = 0;
                model_word = '0;
            end else if (in_valid && exp_ready) begin
                accepted = 1'b1;
                if (model_cnt == M - 1) begin
                    exp_w = {in_bit, model_word[M-2:0]};
                    exp_q.push_back(exp_w);
                    model_out  = exp_w;
                    load       = 1'b1;
                    model_word = '0;
                    model_cnt  = 0;
                end else begin
                    model_word[model_cnt] = in_bit;
                    model_cnt++;
                end
            end
            if (load) model_valid = 1'b1;
            else if (model_valid && out_ready) model_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        cycle_cnt++;
    endtask

    task automatic send_bits(input logic [M-1:0] w, input int nbits);
        bit acc;
        int guard;
        for (int i = 0; i < nbits; i++) begin
            in_valid = 1'b1;
            in_bit   = w[i];
            acc      = 1'b0;
            guard    = 0;
            while (!acc && guard < 50) begin
                tick(acc);
                guard++;
            end
            if (!acc) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout bit=%0d accepted=0 req 1", i);
            end
        end
        in_valid = 1'b0;
        in_bit   = 1'bx;
    endtask

    task automatic test_reset();
        bit acc;
        rst = 1'b1;
        tick(acc);
        tick(acc);
        rst = 1'b0;
        vectors++;
        if (sel !== '0 || out !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset sel=%0d out=%h out_valid=%b in_ready=%b req 0 00 0 1",
                     sel, out, out_valid, in_ready);
        end
    endtask

    task automatic test_basic();
        logic [M-1:0] w;
        bit acc;
        w = 8'hE9;
        out_ready = 1'b1;
        for (int i = 0; i < M; i++) begin
            in_valid = 1'b1;
            in_bit   = w[i];
            vectors++;
            if (sel !== N'(i)) begin
                miscompares++;
                $display("FAIL basic_sel sel=%0d req %0d", sel, i);
            end
            tick(acc);
            vectors++;
            if (!acc) begin
                miscompares++;
                $display("FAIL basic_accept bit=%0d accepted=0 req 1", i);
            end
        end
        in_valid = 1'b0;
        in_bit   = 1'bx;
        vectors++;
        if (out !== 8'hE9 || out_valid !== 1'b1 || sel !== '0) begin
            miscompares++;
            $display("FAIL basic_word out=%h out_valid=%b sel=%0d req e9 1 0", out, out_valid, sel);
        end
        tick(acc);
        vectors++;
        if (out_valid !== 1'b0 || out !== 8'hE9) begin
            miscompares++;
            $display("FAIL basic_pulse out_valid=%b out=%h req 0 e9", out_valid, out);
        end
    endtask

    task automatic test_backpressure();
        logic [M-1:0] w2;
        bit acc;
        w2 = 8'h5A;
        out_ready = 1'b0;
        send_bits(8'hE9, M);
        send_bits(w2, M - 1);
        in_valid = 1'b1;
        in_bit   = w2[M-1];
        vectors++;
        if (sel !== N'(M - 1) || in_ready !== 1'b0 || out !== 8'hE9 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_stall sel=%0d in_ready=%b out=%h out_valid=%b req 7 0 e9 1",
                     sel, in_ready, out, out_valid);
        end
        for (int c = 0; c < 3; c++) begin
            tick(acc);
            vectors++;
            if (acc || in_ready !== 1'b0 || out !== 8'hE9) begin
                miscompares++;
                $display("FAIL bp_hold in_ready=%b out=%h req 0 e9", in_ready, out);
            end
        end
        out_ready = 1'b1;
        tick(acc);
        in_valid = 1'b0;
        in_bit   = 1'bx;
        vectors++;
        if (!acc || out !== 8'h5A || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release accepted=%b out=%h out_valid=%b req 1 5a 1", acc, out, out_valid);
        end
        tick(acc);
    endtask

    task automatic test_bubbles();
        logic [M-1:0] w;
        bit acc;
        w = 8'hC3;
        out_ready = 1'b1;
        for (int i = 0; i < M; i++) begin
            in_valid = 1'b1;
            in_bit   = w[i];
            tick(acc);
            in_valid = 1'b0;
            in_bit   = 1'bx;
            if (i == M - 1) begin
                vectors++;
                if (out !== 8'hC3 || out_valid !== 1'b1 || $isunknown(out)) begin
                    miscompares++;
                    $display("FAIL bubble_word out=%h out_valid=%b req c3 1", out, out_valid);
                end
            end
            tick(acc);
            vectors++;
            if (acc || sel !== N'((i + 1) % M)) begin
                miscompares++;
                $display("FAIL bubble_sel sel=%0d accepted=%b req %0d 0", sel, acc, (i + 1) % M);
            end
        end
    endtask

    task automatic test_clr();
        bit acc;
        out_ready = 1'b0;
        send_bits(8'h81, M);
        send_bits(8'hFF, 3);
        vectors++;
        if (sel !== N'(3)) begin
            miscompares++;
            $display("FAIL clr_pre sel=%0d req 3", sel);
        end
        clr      = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        tick(acc);
        clr      = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'bx;
        vectors++;
        if (acc || sel !== '0 || out !== 8'h81 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_abort sel=%0d out=%h out_valid=%b req 0 81 1", sel, out, out_valid);
        end
        out_ready = 1'b1;
        send_bits(8'h0F, M);
        vectors++;
        if (out !== 8'h0F || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_fresh out=%h out_valid=%b req 0f 1", out, out_valid);
        end
        // clr together with an output handshake: the handshake still completes
        clr      = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        tick(acc);
        clr      = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'bx;
        vectors++;
        if (out_valid !== 1'b0 || out !== 8'h0F || sel !== '0) begin
            miscompares++;
            $display("FAIL clr_consume out_valid=%b out=%h sel=%0d req 0 0f 0", out_valid, out, sel);
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        out_ready = 1'b0;
        send_bits(8'hA5, M);
        send_bits(8'hFF, 4);
        vectors++;
        if (sel !== N'(4) || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_pre sel=%0d out_valid=%b req 4 1", sel, out_valid);
        end
        rst = 1'b1;
        tick(acc);
        rst = 1'b0;
        vectors++;
        if (out !== '0 || out_valid !== 1'b0 || sel !== '0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid out=%h out_valid=%b sel=%0d in_ready=%b req 00 0 0 1",
                     out, out_valid, sel, in_ready);
        end
    endtask

    task automatic test_mux_roundtrip();
        logic seq [M] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [M-1:0] w;
        logic got;
        bit acc;
        for (int i = 0; i < M; i++) w[i] = seq[i];
        out_ready = 1'b0;
        send_bits(w, M);
        for (int k = 0; k < M; k++) begin
            got = mux8(out, k);
            vectors++;
            if (got !== seq[k]) begin
                miscompares++;
                $display("FAIL mux_roundtrip sel=%0d got=%b req %b", k, got, seq[k]);
            end
        end
        out_ready = 1'b1;
        tick(acc);
    endtask

    task automatic test_back_to_back();
        int start;
        bit acc;
        out_ready = 1'b1;
        start = cycle_cnt;
        send_bits(8'h5A, M);
        send_bits(8'h3C, M);
        vectors++;
        if (cycle_cnt - start !== 2 * M || out !== 8'h3C || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL back_to_back cycles=%0d out=%h out_valid=%b req %0d 3c 1",
                     cycle_cnt - start, out, out_valid, 2 * M);
        end
        tick(acc);
    endtask

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_bubbles();
        test_clr();
        test_reset_mid();
        test_mux_roundtrip();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
